// File: rtl/sum_latch_framer_if.sv
// sum_latch_framer_if: start/busy byte handshake between the framer and the UART transmitter.
interface sum_latch_framer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  modport master(output tx_start, output tx_data, input tx_busy);
  modport slave(input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/sum_latch_framer.sv
// sum_latch_framer: debounced A/B operand latch that sends A+B as "DD\r\n" to a UART TX.
module sum_latch_framer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                save_a_n,
  input  logic                save_b_n,
  input  logic [4:0]          data_input,
  sum_latch_framer_if.master  tx,
  output logic [5:0]          sum_out,
  output logic                frame_busy
);
  typedef enum logic [2:0] {IDLE, CONV, SEND, WAIT_HI, WAIT_LO} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t           state_q, state_d;
  logic [1:0]       s1_q, s2_q, db_q, db_d, press;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [4:0]       a_q, a_d, b_q, b_d;
  logic [5:0]       sum_q, sum_d, rem_q, rem_d;
  logic [3:0]       tens_q, tens_d;
  logic [1:0]       idx_q, idx_d;
  logic             pending_q, pending_d, start_q, start_d, fb_q, fb_d;
  logic [7:0]       data_q, data_d, tx_byte;
  // index 0 = A, index 1 = B; the counter only runs while the synced level disagrees
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (s2_q[i] == db_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
      db_d[i]  = (s2_q[i] != db_q[i] && cnt_q[i] == LAST) ? s2_q[i] : db_q[i];
    end
  end
  assign press   = db_q & ~db_d;
  assign tx_byte = idx_q == 2'd0 ? 8'h30 + {4'd0, tens_q} :
                   idx_q == 2'd1 ? 8'h30 + {2'd0, rem_q}  :
                   idx_q == 2'd2 ? 8'h0D : 8'h0A;
  always_comb begin
    state_d   = state_q;
    a_d       = press[0] ? data_input : a_q;
    b_d       = press[1] ? data_input : b_q;
    pending_d = pending_q | (|press);
    sum_d     = sum_q;
    rem_d     = rem_q;
    tens_d    = tens_q;
    idx_d     = idx_q;
    start_d   = 1'b0;
    data_d    = data_q;
    fb_d      = fb_q;
    case (state_q)
      IDLE: if (pending_q) begin
        pending_d = |press;
        sum_d     = {1'b0, a_q} + {1'b0, b_q};
        rem_d     = {1'b0, a_q} + {1'b0, b_q};
        tens_d    = '0;
        fb_d      = 1'b1;
        state_d   = CONV;
      end
      CONV: if (rem_q >= 6'd10) begin
        rem_d  = rem_q - 6'd10;
        tens_d = tens_q + 4'd1;
      end else begin
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: if (!tx.tx_busy) begin
        data_d  = tx_byte;
        start_d = 1'b1;
        state_d = WAIT_HI;
      end
      WAIT_HI: if (tx.tx_busy) state_d = WAIT_LO;
      WAIT_LO: if (!tx.tx_busy) begin
        idx_d   = idx_q + 2'd1;
        fb_d    = idx_q == 2'd3 ? 1'b0 : fb_q;
        state_d = idx_q == 2'd3 ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '1;
      s2_q      <= '1;
      db_q      <= '1;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      pending_q <= 1'b0;
      sum_q     <= '0;
      rem_q     <= '0;
      tens_q    <= '0;
      idx_q     <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      fb_q      <= 1'b0;
    end else begin
      s1_q      <= {save_b_n, save_a_n};
      s2_q      <= s1_q;
      db_q      <= db_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pending_q <= pending_d;
      sum_q     <= sum_d;
      rem_q     <= rem_d;
      tens_q    <= tens_d;
      idx_q     <= idx_d;
      start_q   <= start_d;
      data_q    <= data_d;
      fb_q      <= fb_d;
    end
  end
  assign tx.tx_start = start_q;
  assign tx.tx_data  = data_q;
  assign sum_out     = sum_q;
  assign frame_busy  = fb_q;
endmodule

// File: tb/tb_sum_latch_framer.sv
// tb_sum_latch_framer: scoreboard bench with a UART busy responder and a message-level model.
module tb_sum_latch_framer;
  logic       clk = 0;
  logic       reset_n = 0;
  logic       save_a_n = 1;
  logic       save_b_n = 1;
  logic [4:0] data_input = 0;
  logic [5:0] sum_out;
  logic       frame_busy;
  int         checks = 0;
  int         errors = 0;
  int         n_bytes = 0;
  int         busy_max = 6;
  int         busy_cnt = 0;
  int         model_a = 0;
  int         model_b = 0;
  logic [7:0] last_byte = 0;
  logic [7:0] exp_q [$];

  sum_latch_framer_if bus();

  sum_latch_framer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .data_input(data_input), .tx(bus), .sum_out(sum_out), .frame_busy(frame_busy)
  );

  always #5 clk = ~clk;

  // UART responder: busy rises the cycle after start and stays high a random while
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.tx_busy <= 1'b0;
      busy_cnt    <= 0;
    end else if (bus.tx_start) begin
      bus.tx_busy <= 1'b1;
      busy_cnt    <= $urandom_range(2, busy_max);
    end else if (bus.tx_busy) begin
      if (busy_cnt == 0) bus.tx_busy <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  // monitor: every byte the DUT offers is popped against the scoreboard
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset_n) begin
      if (bus.tx_start) begin
        n_bytes++;
        last_byte = bus.tx_data;
        checks++;
        if (bus.tx_busy) begin
          errors++;
          $display("FAIL start_while_busy busy=%0b required 0", bus.tx_busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte got %h required none", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte got %h required %h", bus.tx_data, e);
          end
          if (e == 8'h0A) begin
            checks++;
            if (frame_busy !== 1'b1) begin
              errors++;
              $display("FAIL frame_busy_at_lf got %0b required 1", frame_busy);
            end
          end
        end
      end else if (bus.tx_busy) begin
        checks++;
        if (bus.tx_data !== last_byte) begin
          errors++;
          $display("FAIL tx_data_held got %h required %h", bus.tx_data, last_byte);
        end
      end
    end
  end

  task automatic push_frame(input int s);
    exp_q.push_back(8'(48 + s / 10));
    exp_q.push_back(8'(48 + s % 10));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic press(input bit pa, input bit pb, input logic [4:0] d);
    data_input = d;
    @(negedge clk);
    save_a_n = !pa;
    save_b_n = !pb;
    repeat (8) @(negedge clk);
    save_a_n = 1;
    save_b_n = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // waits for frame_busy to stay low for several cycles, then checks sum_out
  task automatic wait_idle(input int req_sum);
    int t = 0;
    int low = 0;
    while (low < 6 && t < 4000) begin
      @(negedge clk);
      low = frame_busy ? 0 : low + 1;
      t++;
    end
    checks++;
    if (t >= 4000) begin
      errors++;
      $display("FAIL frame_timeout frame_busy=%0b required 0", frame_busy);
    end
    check("sum_out", int'(sum_out), req_sum);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int t;
    int sel;
    int d;
    repeat (3) @(negedge clk);
    check("rst_tx_start", int'(bus.tx_start), 0);
    check("rst_tx_data", int'(bus.tx_data), 0);
    check("rst_sum_out", int'(sum_out), 0);
    check("rst_frame_busy", int'(frame_busy), 0);
    reset_n = 1;
    repeat (3) @(negedge clk);

    model_a = 5; push_frame(model_a + model_b); press(1, 0, 5'd5); wait_idle(5);
    model_b = 7; push_frame(model_a + model_b); press(0, 1, 5'd7); wait_idle(12);
    model_a = 31; model_b = 31; push_frame(62); press(1, 1, 5'd31); wait_idle(62);

    // short glitch never reaches the debounce threshold
    base = n_bytes;
    data_input = 5'd3;
    save_a_n = 0;
    repeat (3) @(negedge clk);
    save_a_n = 1;
    repeat (40) @(negedge clk);
    check("glitch_no_bytes", n_bytes, base);
    model_b = 4; push_frame(model_a + model_b); press(0, 1, 5'd4); wait_idle(35);

    model_a = 9; model_b = 9; push_frame(18); press(1, 1, 5'd9); wait_idle(18);

    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 2);
      d = $urandom_range(0, 31);
      if (sel != 1) model_a = d;
      if (sel != 0) model_b = d;
      push_frame(model_a + model_b);
      press(sel != 1, sel != 0, 5'(d));
      wait_idle(model_a + model_b);
    end

    // reset after the second byte of a frame is launched
    busy_max = 20;
    base = n_bytes;
    model_a = 3;
    push_frame(model_a + model_b);
    press(1, 0, 5'd3);
    t = 0;
    while (n_bytes < base + 2 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("second_byte_seen", n_bytes, base + 2);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    check("midrst_tx_start", int'(bus.tx_start), 0);
    check("midrst_frame_busy", int'(frame_busy), 0);
    check("midrst_sum_out", int'(sum_out), 0);
    exp_q.delete();
    model_a = 0;
    model_b = 0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1;
    repeat (60) @(negedge clk);
    check("no_resume", n_bytes, base + 2);

    // presses during an in-flight frame coalesce into one further frame
    push_frame(0);
    press(1, 0, 5'd0);
    press(0, 1, 5'd1);
    press(0, 1, 5'd2);
    model_b = 2;
    push_frame(2);
    wait_idle(2);
    busy_max = 6;
    repeat (60) @(negedge clk);
    check("no_third_frame", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
